// File: rtl/iiitb_r2_bm_arbiter.sv
// Arbiter/sequencer sharing one 4-bit radix-2 Booth multiplier among NREQ requesters.
// Define BM_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module iiitb_r2_bm_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_m,
    input  logic [4*NREQ-1:0] req_q,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [7:0]        rsp_p,
    input  logic              rsp_ready,
    output logic              mul_load,
    output logic [3:0]        mul_m,
    output logic [3:0]        mul_q,
    input  logic [7:0]        mul_p,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       mul_load_q, mul_load_d;
    logic [3:0] mul_m_q, mul_m_d;
    logic [3:0] mul_q_q, mul_q_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [2:0] rsp_id_q, rsp_id_d;
    logic [7:0] rsp_p_q, rsp_p_d;
    logic       busy_q, busy_d;
    logic       gnt_any;
    logic [2:0] gnt_idx;

`ifdef BM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = 3'(k);
            end
        end
    end
`else
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] rot;
    logic [3:0]      sum;

    // Rotate requests so the search starts at bit 0, then map back to an absolute index.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        rot     = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_any && rot[k]) begin
                gnt_any = 1'b1;
                sum     = {1'b0, rr_ptr_q} + 4'(k);
                if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
                gnt_idx = sum[2:0];
            end
        end
    end
`endif

    assign req_ready = (state_q == IDLE && gnt_any && !reset) ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_id_d    = gnt_id_q;
        mul_load_d  = mul_load_q;
        mul_m_d     = mul_m_q;
        mul_q_d     = mul_q_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        busy_d      = busy_q;
`ifndef BM_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d    = LOAD;
                    gnt_id_d   = gnt_idx;
                    mul_m_d    = 4'(req_m >> {gnt_idx, 2'b00});
                    mul_q_d    = 4'(req_q >> {gnt_idx, 2'b00});
                    mul_load_d = 1'b1;
                    busy_d     = 1'b1;
`ifndef BM_ARB_FIXED_PRIO_EN
                    rr_ptr_d   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 3'd1;
`endif
                end
            end
            LOAD: begin
                state_d    = RUN;
                mul_load_d = 1'b0;
                cnt_d      = 4'(MUL_CYCLES - 1);
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_p_d     = mul_p;
                    rsp_id_d    = gnt_id_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_id_q    <= '0;
            mul_load_q  <= 1'b0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
`ifndef BM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_id_q    <= gnt_id_d;
            mul_load_q  <= mul_load_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            busy_q      <= busy_d;
`ifndef BM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign mul_load  = mul_load_q;
    assign mul_m     = mul_m_q;
    assign mul_q     = mul_q_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_iiitb_r2_bm_arbiter.sv
// Bench for iiitb_r2_bm_arbiter: transaction-timeline reference model, directed cases, random traffic.
module tb_iiitb_r2_bm_arbiter #(
    parameter int MC = 4
);
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [4*NREQ-1:0] req_m = '0;
    logic [4*NREQ-1:0] req_q = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [7:0]        rsp_p;
    logic              rsp_ready = 1'b0;
    logic              mul_load;
    logic [3:0]        mul_m;
    logic [3:0]        mul_q;
    logic [7:0]        mul_p = '0;
    logic              busy;

    iiitb_r2_bm_arbiter #(.NREQ(NREQ), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_m(req_m), .req_q(req_q),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .rsp_ready(rsp_ready), .mul_load(mul_load), .mul_m(mul_m), .mul_q(mul_q),
        .mul_p(mul_p), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int sa, sb;
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        return 8'(sa * sb);
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int j = 0; j < NREQ; j++) begin
`ifdef BM_ARB_FIXED_PRIO_EN
            if (v[j]) return j + 0 * rr;
`else
            if (v[(rr + j) % NREQ]) return (rr + j) % NREQ;
`endif
        end
        return -1;
    endfunction

    // Multiplier stand-in: product is valid from MC cycles after the load cycle, junk before.
    int cd = -1;
    logic [3:0] lm = '0, lq = '0;
    always @(negedge clk) begin
        if (mul_load) begin lm = mul_m; lq = mul_q; cd = MC; end
        else if (cd > 0) cd--;
        mul_p = (cd == 0) ? prod(lm, lq) : 8'($urandom);
    end

    // Reference model: each grant opens a timeline (load at +1, response from +2+MC).
    int cyc = 0;
    bit m_act = 0;
    int m_t = 0, m_id = 0, m_rr = 0;
    logic [3:0] e_m = '0, e_q = '0;
    logic [7:0] e_p = '0, m_prod = '0;
    logic [2:0] e_id = '0;
    always @(negedge clk) begin : model
        int k, gi;
        logic [NREQ-1:0] e_ready;
        bit e_load, e_busy, e_rv;
        cyc++;
        if (reset) begin
            m_act = 0; m_rr = 0; e_m = '0; e_q = '0; e_p = '0; e_id = '0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_p", 32'(rsp_p), 0);
            chk("rst_mul_load", 32'(mul_load), 0);
            chk("rst_mul_m", 32'(mul_m), 0);
            chk("rst_mul_q", 32'(mul_q), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            e_ready = '0; e_load = 0; e_busy = 0; e_rv = 0; gi = -1;
            if (m_act) begin
                k = cyc - m_t;
                e_busy = 1; e_load = (k == 1); e_rv = (k >= 2 + MC);
                if (k == 2 + MC) begin e_p = m_prod; e_id = 3'(m_id); end
            end else begin
                gi = pick(req_valid, m_rr);
                if (gi >= 0) e_ready[gi] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_id", 32'(rsp_id), 32'(e_id));
            chk("rsp_p", 32'(rsp_p), 32'(e_p));
            chk("mul_load", 32'(mul_load), 32'(e_load));
            chk("mul_m", 32'(mul_m), 32'(e_m));
            chk("mul_q", 32'(mul_q), 32'(e_q));
            chk("busy", 32'(busy), 32'(e_busy));
            if (gi >= 0) begin
                m_act = 1; m_t = cyc; m_id = gi;
                e_m = req_m[4*gi +: 4]; e_q = req_q[4*gi +: 4];
                m_prod = prod(e_m, e_q);
                m_rr = (gi + 1) % NREQ;
            end else if (m_act && e_rv && rsp_ready) begin
                m_act = 0;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_grant(input int i, output bit got);
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output bit got);
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        if (!got) chk("rsp_timeout", 0, 1);
    endtask

    task automatic send(input int i, input logic [3:0] m, input logic [3:0] q,
                        output int lat, output int ld, output logic [7:0] p, output logic [2:0] id);
        bit got;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_m[4*i +: 4] = m; req_q[4*i +: 4] = q;
        wait_grant(i, got);
        lat = -1; ld = -1; p = '0; id = '0;
        if (got) begin
            @(posedge clk); #1 req_valid[i] = 1'b0;
            for (int n = 1; n < 100; n++) begin
                if (n > 1) @(negedge clk);
                else @(negedge clk);
                if (mul_load && ld < 0) ld = n;
                if (rsp_valid) begin lat = n; break; end
            end
            p = rsp_p; id = rsp_id;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int lat, ld, nseen;
        logic [7:0] p;
        logic [2:0] id;
        int gidx[5], gcyc[5], exp_ord[5];
        bit got;
        logic [NREQ-1:0] g;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;

        // Requester 0: -6 * -5 = 30
        send(0, 4'b1010, 4'b1011, lat, ld, p, id);
        chk("t1_load_cycle", 32'(ld), 1);
        chk("t1_latency", 32'(lat), 32'(2 + MC));
        chk("t1_p", 32'(p), 32'h1E);
        chk("t1_id", 32'(id), 0);

        // Requester 2: 7 * -8 = -56
        send(2, 4'b0111, 4'b1000, lat, ld, p, id);
        chk("t2_p", 32'(p), 32'hC8);
        chk("t2_id", 32'(id), 2);

        send(1, 4'b0000, 4'b1101, lat, ld, p, id);
        chk("t3_zero_p", 32'(p), 0);
        chk("t3_id", 32'(id), 1);

        // All requesters continuously valid
        pulse_reset();
        rsp_ready = 1'b1;
        req_m = 16'h4321; req_q = 16'h5B7E;
        req_valid = '1;
        nseen = 0;
        for (int c = 0; c < 200 && nseen < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gidx[nseen] = -1;
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) gidx[nseen] = j;
                gcyc[nseen] = c;
                nseen++;
            end
        end
        @(posedge clk); #1 req_valid = '0;
`ifdef BM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        chk("rr_count", 32'(nseen), 5);
        for (int j = 0; j < 5; j++) chk($sformatf("rr_order%0d", j), 32'(gidx[j]), 32'(exp_ord[j]));
        chk("rr_spacing", 32'(gcyc[1] - gcyc[0]), 32'(MC + 3));

        // Response stall with other requests pending
        pulse_reset();
        rsp_ready = 1'b0;
        req_m[15:12] = 4'b1111; req_q[15:12] = 4'b0111;
        req_valid[3] = 1'b1;
        wait_grant(3, got);
        @(posedge clk); #1 req_valid = 4'b0011;
        wait_rsp(got);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_p", 32'(rsp_p), 32'hF9);
            chk("stall_id", 32'(rsp_id), 3);
            chk("stall_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("accept_cycle_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        chk("idle_after_accept", 32'(busy), 0);
        chk("regrant_after_accept", 32'(req_ready), 32'b0001);
        @(posedge clk); #1 req_valid[0] = 1'b0;

        // Reset during RUN: in-flight request 2 is dropped, search restarts at 0
        pulse_reset();
        rsp_ready = 1'b1;
        req_m[11:8] = 4'b0011; req_q[11:8] = 4'b0011;
        req_valid[2] = 1'b1;
        wait_grant(2, got);
        @(posedge clk); #1;
        req_valid = 4'b1010;
        req_m[7:4] = 4'b1110; req_q[7:4] = 4'b0101;
        req_m[15:12] = 4'b0110; req_q[15:12] = 4'b0010;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("rr_busy0", 32'(busy), 0);
        chk("rr_load0", 32'(mul_load), 0);
        chk("rr_m0", 32'(mul_m), 0);
        chk("rr_q0", 32'(mul_q), 0);
        chk("rr_rv0", 32'(rsp_valid), 0);
        chk("rr_id0", 32'(rsp_id), 0);
        chk("rr_p0", 32'(rsp_p), 0);
        chk("rr_ready0", 32'(req_ready), 0);
        @(posedge clk); #1 reset = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = (req_ready != '0); end
        chk("post_reset_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(got);
        chk("post_reset_id", 32'(rsp_id), 1);
        chk("post_reset_p", 32'(rsp_p), 32'hF6);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk); #1;
            req_valid = req_valid & ~g;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_m[4*i +: 4] = 4'($urandom);
                    req_q[4*i +: 4] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(2) != 0);
            reset = ($urandom_range(399) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready = 1'b1; req_valid = '0;
        repeat (3 * MC + 20) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iiitb_r2_bm_arbiter.md
# iiitb_r2_bm_arbiter

Request arbiter and sequencer that shares a single 4-bit radix-2 Booth multiplier among `NREQ` requesters. It accepts multiply requests over a valid/ready handshake and selects one requester round-robin. It pulses the multiplier's `load`, waits the fixed iteration count, captures the signed 8-bit product and returns it tagged with the requester index. It sits between client blocks and the multiplier's `clk/load/reset/M/Q/P` port set.

## Interface
- `NREQ`, 4, number of requesters; legal 2..8
- `MUL_CYCLES`, 4, cycles from end of load pulse to valid `P` on multiplier; legal 1..15
- `clk`  in  1  single clock, all state rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req_valid`  in  NREQ  request pending, bit i = requester i
- `req_m`  in  4*NREQ  multiplicand, slice [4i+3:4i] for requester i, two's complement
- `req_q`  in  4*NREQ  multiplier, same slicing
- `req_ready`  out  NREQ  one-hot grant; handshake for requester i completes on the edge where `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  product available
- `rsp_id`  out  3  index of the requester that owns `rsp_p`
- `rsp_p`  out  8  signed product
- `rsp_ready`  in  1  consumer accepts response
- `mul_load`  out  1  to multiplier `load`
- `mul_m`  out  4  to multiplier `M`
- `mul_q`  out  4  to multiplier `Q`
- `mul_p`  in  8  from multiplier `P`
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any `req_valid` is set, assert exactly one `req_ready` bit, chosen by the priority rule.
  - On that edge, register `req_m`/`req_q` slices and the index, then go to LOAD.
  - `req_ready` is never asserted outside IDLE.
- Round-robin priority: search starts at pointer `rr_ptr` and wraps modulo `NREQ`. On each grant, `rr_ptr` becomes granted index + 1, wrapping `NREQ-1` to 0.
- LOAD: `mul_load`=1 for exactly one cycle, with `mul_m`/`mul_q` driven from the registered operands. Next state is RUN, with cycle counter loaded to `MUL_CYCLES-1`.
- RUN:
  - `mul_load`=0; `mul_m`/`mul_q` are held stable.
  - The counter decrements each cycle.
  - When the counter is 0, capture `mul_p` into `rsp_p` on that edge and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_p` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - A stalled `rsp_ready` holds RESP indefinitely.
- Requesters must hold `req_valid` and operands stable until granted. A deasserted `req_valid` before grant is simply not arbitrated.
- Arithmetic: operands and product are two's complement. `rsp_p` is the multiplier output passed through unmodified.
- Reset mid-operation:
  - FSM returns to IDLE and `rr_ptr` is set to 0.
  - The in-flight request is dropped with no response.
  - The multiplier's own reset is not driven by this block.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0, `mul_load`=0, `mul_m`=0, `mul_q`=0, `busy`=0.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and state; all other outputs are registered.
- Grant at cycle T (edge ending T) gives:
  - LOAD in cycle T+1
  - RUN in cycles T+2 .. T+1+MUL_CYCLES
  - `rsp_valid` from cycle T+2+MUL_CYCLES
  - Default latency: response 6 cycles after grant.
- Response accepted at cycle R gives IDLE at R+1, so the next grant is possible at R+1. Minimum request-to-request spacing is MUL_CYCLES+3 cycles.
- A `req_valid` arriving while busy waits. The arbitration decision is made only in IDLE, using current `rr_ptr`.

## Configuration
- `BM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `rr_ptr` is removed.
  - Undefined (default): round-robin as above.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then requester 0 sends M=1010, Q=1011 → `mul_load` pulse 1 cycle after grant; `rsp_valid` 6 cycles after grant with `rsp_p`=00011110 (30), `rsp_id`=0.
- Requesters 0..3 all valid simultaneously, `rsp_ready` tied 1 → grants in order 0,1,2,3, then wraps to 0. Compiled with `BM_ARB_FIXED_PRIO_EN`: 0 repeatedly while held valid.
- Requester 2 sends M=0111, Q=1000 → `rsp_p`=11001000 (-56), `rsp_id`=2. Also M=0000, any Q → 0.
- Hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`, `rsp_p`, `rsp_id` stable; `req_ready` stays 0 despite pending requests; IDLE one cycle after `rsp_ready`.
- Assert `reset` during RUN → all outputs 0 immediately. After release, pending request is re-granted starting from index 0, with no stale response.
- `MUL_CYCLES`=1 build → `rsp_valid` 3 cycles after grant.
